// File: rtl/ring_osc_sweep_ctrl.sv
// Ring-oscillator tap controller: per tap, settle / measure / settle / capture, optional sweep of taps 0..7.
// Define RING_OSC_MAX_TRACK_EN to enable running-max tracking on max_count/max_tap.
module ring_osc_sweep_ctrl #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sweep,
  input  logic [2:0]  tap_sel,
  input  logic [15:0] window,
  input  logic [14:0] osc_count,
  output logic [2:0]  tap,
  output logic        osc_en,
  output logic        busy,
  output logic        res_valid,
  output logic [2:0]  res_tap,
  output logic [14:0] res_count,
  output logic        done,
  output logic [14:0] max_count,
  output logic [2:0]  max_tap
);

  localparam int unsigned TAP_W = 3;
  localparam int unsigned CNT_W = 15;
  localparam int unsigned TMR_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    HOLD    = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             sweep_q, sweep_d;
  logic [TMR_W-1:0] win_q, win_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             osc_en_q, osc_en_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [TAP_W-1:0] res_tap_q, res_tap_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             done_q, done_d;

`ifdef RING_OSC_MAX_TRACK_EN
  logic [CNT_W-1:0] max_count_q, max_count_d;
  logic [TAP_W-1:0] max_tap_q, max_tap_d;
`endif

  // Next-state and output decode; abort overrides every transition and holds all results.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sweep_d     = sweep_q;
    win_d       = win_q;
    tap_d       = tap_q;
    res_tap_d   = res_tap_q;
    res_count_d = res_count_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
`ifdef RING_OSC_MAX_TRACK_EN
    max_count_d = max_count_q;
    max_tap_d   = max_tap_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (window != '0)) begin
            state_d = ARM;
            sweep_d = sweep;
            win_d   = window;
            tap_d   = sweep ? '0 : tap_sel;
            cnt_d   = TMR_W'(SETTLE - 1);
`ifdef RING_OSC_MAX_TRACK_EN
            max_count_d = '0;
            max_tap_d   = '0;
`endif
          end
        end
        ARM: begin
          if (cnt_q == '0) begin
            state_d = MEASURE;
            cnt_d   = TMR_W'(win_q - TMR_W'(1));
          end else begin
            cnt_d = TMR_W'(cnt_q - TMR_W'(1));
          end
        end
        MEASURE: begin
          if (cnt_q == '0) begin
            state_d = HOLD;
            cnt_d   = TMR_W'(SETTLE - 1);
          end else begin
            cnt_d = TMR_W'(cnt_q - TMR_W'(1));
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = TMR_W'(cnt_q - TMR_W'(1));
          end
        end
        CAPTURE: begin
          res_valid_d = 1'b1;
          res_tap_d   = tap_q;
          res_count_d = osc_count;
`ifdef RING_OSC_MAX_TRACK_EN
          if (osc_count > max_count_q) begin
            max_count_d = osc_count;
            max_tap_d   = tap_q;
          end
`endif
          if (sweep_q && (tap_q != 3'd7)) begin
            state_d = ARM;
            tap_d   = TAP_W'(tap_q + TAP_W'(1));
            cnt_d   = TMR_W'(SETTLE - 1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    osc_en_d = (state_d == MEASURE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sweep_q     <= 1'b0;
      win_q       <= '0;
      tap_q       <= '0;
      osc_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_tap_q   <= '0;
      res_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sweep_q     <= sweep_d;
      win_q       <= win_d;
      tap_q       <= tap_d;
      osc_en_q    <= osc_en_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_tap_q   <= res_tap_d;
      res_count_q <= res_count_d;
      done_q      <= done_d;
    end
  end

`ifdef RING_OSC_MAX_TRACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      max_count_q <= '0;
      max_tap_q   <= '0;
    end else begin
      max_count_q <= max_count_d;
      max_tap_q   <= max_tap_d;
    end
  end
  assign max_count = max_count_q;
  assign max_tap   = max_tap_q;
`else
  assign max_count = '0;
  assign max_tap   = '0;
`endif

  assign tap       = tap_q;
  assign osc_en    = osc_en_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_tap   = res_tap_q;
  assign res_count = res_count_q;
  assign done      = done_q;

endmodule
